// File: rtl/exe_pkg.sv
// Shared definitions for the EXE operand stage: ALU command codes,
// default datapath widths and the forward-select encoding.
package exe_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  localparam logic [3:0] CMD_ADD    = 4'd0;
  localparam logic [3:0] CMD_SUB    = 4'd2;
  localparam logic [3:0] CMD_AND    = 4'd4;
  localparam logic [3:0] CMD_OR     = 4'd5;
  localparam logic [3:0] CMD_NOR    = 4'd6;
  localparam logic [3:0] CMD_XOR    = 4'd7;
  localparam logic [3:0] CMD_LEFT   = 4'd8;
  localparam logic [3:0] CMD_SRIGHT = 4'd9;
  localparam logic [3:0] CMD_RIGHT  = 4'd10;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/forward_mux.sv
// Operand forwarding selector: picks the MEM result, the WB value or the
// registered operand for one source register. MEM is the younger result and
// therefore wins over WB; register 0 is hard-wired and never forwarded.
module forward_mux
  import exe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] i_src,
  input  logic [DW-1:0] i_reg_val,
  input  logic          i_mem_en,
  input  logic [RW-1:0] i_mem_dest,
  input  logic [DW-1:0] i_mem_val,
  input  logic          i_wb_en,
  input  logic [RW-1:0] i_wb_dest,
  input  logic [DW-1:0] i_wb_val,
  output logic [DW-1:0] o_val,
  output fwd_sel_e      o_sel
);

  logic w_src_nz;
  assign w_src_nz = (i_src != {RW{1'b0}});

  // Select the newest producer of the source register, falling back to the register file copy
  always_comb begin
    o_val = i_reg_val;
    o_sel = FWD_REG;
    if (i_mem_en && (i_mem_dest == i_src) && w_src_nz) begin
      o_val = i_mem_val;
      o_sel = FWD_MEM;
    end else if (i_wb_en && (i_wb_dest == i_src) && w_src_nz) begin
      o_val = i_wb_val;
      o_sel = FWD_WB;
    end else begin
      o_val = i_reg_val;
      o_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/exe_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Optional feature macro: FORWARDING_EN. When undefined, the MEM/WB
// forwarding inputs are ignored and load_use flags every RAW dependency on EXE.
module exe_operand_stage
  import exe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_val1,
  input  logic [DW-1:0] id_val2,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [3:0]    id_cmd,
  input  logic [RW-1:0] id_src1,
  input  logic [RW-1:0] id_src2,
  input  logic [RW-1:0] id_dest,
  input  logic          id_wb_en,
  input  logic          id_mem_r,
  input  logic          id_mem_w,
  input  logic          mem_wb_en,
  input  logic [RW-1:0] mem_dest,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_wb_en,
  input  logic [RW-1:0] wb_dest,
  input  logic [DW-1:0] wb_value,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_cmd,
  output logic          exe_valid,
  output logic          exe_wb_en,
  output logic          exe_mem_r,
  output logic          exe_mem_w,
  output logic [RW-1:0] exe_dest,
  output logic [DW-1:0] exe_store_val,
  output logic          load_use
);

  logic          r_valid, r_wb_en, r_mem_r, r_mem_w, r_use_imm;
  logic [DW-1:0] r_val1, r_val2, r_imm;
  logic [3:0]    r_cmd;
  logic [RW-1:0] r_src1, r_src2, r_dest;

  // Pipeline register: flush loads a bubble, freeze holds, otherwise capture ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_wb_en   <= 1'b0;
      r_mem_r   <= 1'b0;
      r_mem_w   <= 1'b0;
      r_use_imm <= 1'b0;
      r_val1    <= {DW{1'b0}};
      r_val2    <= {DW{1'b0}};
      r_imm     <= {DW{1'b0}};
      r_cmd     <= CMD_ADD;
      r_src1    <= {RW{1'b0}};
      r_src2    <= {RW{1'b0}};
      r_dest    <= {RW{1'b0}};
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_wb_en   <= 1'b0;
      r_mem_r   <= 1'b0;
      r_mem_w   <= 1'b0;
      r_use_imm <= 1'b0;
      r_val1    <= {DW{1'b0}};
      r_val2    <= {DW{1'b0}};
      r_imm     <= {DW{1'b0}};
      r_cmd     <= CMD_ADD;
      r_src1    <= {RW{1'b0}};
      r_src2    <= {RW{1'b0}};
      r_dest    <= {RW{1'b0}};
    end else if (!freeze) begin
      r_valid   <= id_valid;
      r_wb_en   <= id_valid & id_wb_en;
      r_mem_r   <= id_valid & id_mem_r;
      r_mem_w   <= id_valid & id_mem_w;
      r_use_imm <= id_use_imm;
      r_val1    <= id_val1;
      r_val2    <= id_val2;
      r_imm     <= id_imm;
      r_cmd     <= id_cmd;
      r_src1    <= id_src1;
      r_src2    <= id_src2;
      r_dest    <= id_dest;
    end else begin
      r_valid   <= r_valid;
      r_wb_en   <= r_wb_en;
      r_mem_r   <= r_mem_r;
      r_mem_w   <= r_mem_w;
      r_use_imm <= r_use_imm;
      r_val1    <= r_val1;
      r_val2    <= r_val2;
      r_imm     <= r_imm;
      r_cmd     <= r_cmd;
      r_src1    <= r_src1;
      r_src2    <= r_src2;
      r_dest    <= r_dest;
    end
  end

  logic          w_mem_en, w_wb_en, w_load_term, w_unused_sink;
  logic [RW-1:0] w_mem_dest, w_wb_dest;
  logic [DW-1:0] w_mem_val, w_wb_val, w_fwd1, w_fwd2;
  fwd_sel_e      w_sel1, w_sel2;

`ifdef FORWARDING_EN
  assign w_mem_en      = mem_wb_en;
  assign w_mem_dest    = mem_dest;
  assign w_mem_val     = mem_result;
  assign w_wb_en       = wb_wb_en;
  assign w_wb_dest     = wb_dest;
  assign w_wb_val      = wb_value;
  assign w_load_term   = r_mem_r;
  assign w_unused_sink = ^{w_sel1, w_sel2};
`else
  assign w_mem_en      = 1'b0;
  assign w_mem_dest    = {RW{1'b0}};
  assign w_mem_val     = {DW{1'b0}};
  assign w_wb_en       = 1'b0;
  assign w_wb_dest     = {RW{1'b0}};
  assign w_wb_val      = {DW{1'b0}};
  // Without forwarding every producer in EXE blocks a dependent instruction
  assign w_load_term   = 1'b1;
  assign w_unused_sink = ^{w_sel1, w_sel2, mem_wb_en, mem_dest, mem_result,
                           wb_wb_en, wb_dest, wb_value};
`endif

  forward_mux #(.DW(DW), .RW(RW)) u_fwd1 (
    .i_src(r_src1), .i_reg_val(r_val1),
    .i_mem_en(w_mem_en), .i_mem_dest(w_mem_dest), .i_mem_val(w_mem_val),
    .i_wb_en(w_wb_en), .i_wb_dest(w_wb_dest), .i_wb_val(w_wb_val),
    .o_val(w_fwd1), .o_sel(w_sel1)
  );

  forward_mux #(.DW(DW), .RW(RW)) u_fwd2 (
    .i_src(r_src2), .i_reg_val(r_val2),
    .i_mem_en(w_mem_en), .i_mem_dest(w_mem_dest), .i_mem_val(w_mem_val),
    .i_wb_en(w_wb_en), .i_wb_dest(w_wb_dest), .i_wb_val(w_wb_val),
    .o_val(w_fwd2), .o_sel(w_sel2)
  );

  assign alu_a         = w_fwd1;
  assign alu_b         = r_use_imm ? r_imm : w_fwd2;
  assign exe_store_val = w_fwd2;
  assign alu_cmd       = r_cmd;
  assign exe_valid     = r_valid;
  assign exe_wb_en     = r_wb_en;
  assign exe_mem_r     = r_mem_r;
  assign exe_mem_w     = r_mem_w;
  assign exe_dest      = r_dest;

  // A dependent instruction in ID that forwarding cannot serve in time
  assign load_use = r_valid && w_load_term && (r_dest != {RW{1'b0}}) &&
                    ((r_dest == id_src1) || ((r_dest == id_src2) && !id_use_imm));

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed testbench for exe_operand_stage; expectations adapt to FORWARDING_EN.
module tb_exe_operand_stage;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, freeze, flush, id_valid, id_use_imm;
  logic [31:0] id_val1, id_val2, id_imm, mem_result, wb_value;
  logic [3:0]  id_cmd;
  logic [4:0]  id_src1, id_src2, id_dest, mem_dest, wb_dest;
  logic        id_wb_en, id_mem_r, id_mem_w, mem_wb_en, wb_wb_en;
  logic [31:0] alu_a, alu_b, exe_store_val;
  logic [3:0]  alu_cmd;
  logic        exe_valid, exe_wb_en, exe_mem_r, exe_mem_w, load_use;
  logic [4:0]  exe_dest;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exe_operand_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_cmd(id_cmd), .id_src1(id_src1), .id_src2(id_src2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .exe_valid(exe_valid), .exe_wb_en(exe_wb_en), .exe_mem_r(exe_mem_r),
    .exe_mem_w(exe_mem_w), .exe_dest(exe_dest), .exe_store_val(exe_store_val),
    .load_use(load_use)
  );

  // Drive one decoded instruction onto the ID inputs (stimulus only)
  task automatic drive_id(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          input logic mr);
    id_valid = 1'b1; id_cmd = cmd; id_val1 = v1; id_val2 = v2;
    id_src1 = s1; id_src2 = s2; id_dest = d; id_wb_en = 1'b1;
    id_mem_r = mr; id_mem_w = 1'b0; id_use_imm = 1'b0; id_imm = 32'h0;
  endtask

  task automatic clear_fwd();
    mem_wb_en = 1'b0; mem_dest = 5'd0; mem_result = 32'h0;
    wb_wb_en = 1'b0; wb_dest = 5'd0; wb_value = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_id(4'd0, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    n_checks++;
    if (exe_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_valid: got %b want 1", exe_valid); end
    #2 rst = 1'b1; #1;
    n_checks++;
    if (alu_a !== 32'h0) begin n_fail++; $display("FAIL reset_alu_a: got %h want 0", alu_a); end
    n_checks++;
    if (alu_b !== 32'h0) begin n_fail++; $display("FAIL reset_alu_b: got %h want 0", alu_b); end
    n_checks++;
    if (exe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", exe_valid); end
    n_checks++;
    if (exe_wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en: got %b want 0", exe_wb_en); end
    n_checks++;
    if (exe_dest !== 5'd0) begin n_fail++; $display("FAIL reset_dest: got %0d want 0", exe_dest); end
    n_checks++;
    if (alu_cmd !== 4'd0) begin n_fail++; $display("FAIL reset_cmd: got %0d want 0", alu_cmd); end
    n_checks++;
    if (load_use !== 1'b0) begin n_fail++; $display("FAIL reset_load_use: got %b want 0", load_use); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_capture();
    drive_id(4'd2, 32'd10, 32'd3, 5'd1, 5'd2, 5'd4, 1'b0);
    tick();
    n_checks++;
    if (alu_a !== 32'd10) begin n_fail++; $display("FAIL capture_alu_a: got %h want %h", alu_a, 32'd10); end
    n_checks++;
    if (alu_b !== 32'd3) begin n_fail++; $display("FAIL capture_alu_b: got %h want %h", alu_b, 32'd3); end
    n_checks++;
    if (alu_cmd !== 4'd2) begin n_fail++; $display("FAIL capture_cmd: got %0d want 2", alu_cmd); end
    n_checks++;
    if (exe_dest !== 5'd4) begin n_fail++; $display("FAIL capture_dest: got %0d want 4", exe_dest); end
    n_checks++;
    if (exe_wb_en !== 1'b1) begin n_fail++; $display("FAIL capture_wb_en: got %b want 1", exe_wb_en); end
    // An invalid ID slot must store its control bits as zero
    id_valid = 1'b0; id_mem_w = 1'b1;
    tick();
    n_checks++;
    if (exe_wb_en !== 1'b0 || exe_mem_w !== 1'b0 || exe_valid !== 1'b0) begin
      n_fail++; $display("FAIL capture_invalid_ctrl: got v=%b wb=%b mw=%b want 0 0 0", exe_valid, exe_wb_en, exe_mem_w);
    end
  endtask

  task automatic test_priority();
    logic [31:0] exp;
    drive_id(4'd0, 32'h11, 32'h22, 5'd5, 5'd6, 5'd8, 1'b0);
    tick();
    mem_wb_en = 1'b1; mem_dest = 5'd5; mem_result = 32'hAA;
    wb_wb_en = 1'b1; wb_dest = 5'd5; wb_value = 32'hBB;
    #1;
    exp = FWD ? 32'hAA : 32'h11;
    n_checks++;
    if (alu_a !== exp) begin n_fail++; $display("FAIL prio_mem_over_wb: got %h want %h", alu_a, exp); end
    mem_wb_en = 1'b0; #1;
    exp = FWD ? 32'hBB : 32'h11;
    n_checks++;
    if (alu_a !== exp) begin n_fail++; $display("FAIL prio_wb_only: got %h want %h", alu_a, exp); end
    n_checks++;
    if (alu_b !== 32'h22) begin n_fail++; $display("FAIL prio_b_untouched: got %h want %h", alu_b, 32'h22); end
    drive_id(4'd0, 32'h33, 32'h22, 5'd0, 5'd6, 5'd8, 1'b0);
    mem_wb_en = 1'b1; mem_dest = 5'd0; wb_dest = 5'd0;
    tick();
    n_checks++;
    if (alu_a !== 32'h33) begin n_fail++; $display("FAIL prio_reg0: got %h want %h", alu_a, 32'h33); end
    clear_fwd();
  endtask

  task automatic test_imm_store();
    logic [31:0] exp;
    drive_id(4'd8, 32'h1, 32'h22, 5'd1, 5'd6, 5'd9, 1'b0);
    id_use_imm = 1'b1; id_imm = 32'd4;
    wb_wb_en = 1'b1; wb_dest = 5'd6; wb_value = 32'hBB;
    tick();
    n_checks++;
    if (alu_b !== 32'd4) begin n_fail++; $display("FAIL imm_alu_b: got %h want %h", alu_b, 32'd4); end
    exp = FWD ? 32'hBB : 32'h22;
    n_checks++;
    if (exe_store_val !== exp) begin n_fail++; $display("FAIL imm_store_val: got %h want %h", exe_store_val, exp); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    logic exp;
    drive_id(4'd0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd7, 1'b1);
    tick();
    id_src1 = 5'd7; id_src2 = 5'd0; id_use_imm = 1'b0; #1;
    n_checks++;
    if (load_use !== 1'b1) begin n_fail++; $display("FAIL lu_src1: got %b want 1", load_use); end
    id_src1 = 5'd0; id_src2 = 5'd7; id_use_imm = 1'b1; #1;
    n_checks++;
    if (load_use !== 1'b0) begin n_fail++; $display("FAIL lu_src2_imm: got %b want 0", load_use); end
    id_use_imm = 1'b0; #1;
    n_checks++;
    if (load_use !== 1'b1) begin n_fail++; $display("FAIL lu_src2_reg: got %b want 1", load_use); end
    @(negedge clk);
    drive_id(4'd0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd7, 1'b0);
    tick();
    id_src1 = 5'd7; #1;
    exp = FWD ? 1'b0 : 1'b1;
    n_checks++;
    if (load_use !== exp) begin n_fail++; $display("FAIL lu_nonload: got %b want %b", load_use, exp); end
    @(negedge clk);
    drive_id(4'd0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 1'b1);
    tick();
    id_src1 = 5'd0; #1;
    n_checks++;
    if (load_use !== 1'b0) begin n_fail++; $display("FAIL lu_dest0: got %b want 0", load_use); end
  endtask

  task automatic test_flush_freeze();
    drive_id(4'd2, 32'h44, 32'h45, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    freeze = 1'b1; flush = 1'b1;
    tick();
    n_checks++;
    if (exe_valid !== 1'b0 || alu_cmd !== 4'd0) begin
      n_fail++; $display("FAIL flush_wins: got v=%b cmd=%0d want 0 0", exe_valid, alu_cmd);
    end
    freeze = 1'b0; flush = 1'b0;
    drive_id(4'd5, 32'h55, 32'h66, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    freeze = 1'b1;
    drive_id(4'd7, 32'h99, 32'h98, 5'd3, 5'd4, 5'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (alu_a !== 32'h55 || alu_cmd !== 4'd5 || exe_dest !== 5'd9) begin
        n_fail++; $display("FAIL freeze_hold_%0d: got a=%h cmd=%0d d=%0d want 55 5 9", i, alu_a, alu_cmd, exe_dest);
      end
    end
    #2 rst = 1'b1; #1;
    n_checks++;
    if (exe_valid !== 1'b0 || alu_a !== 32'h0) begin
      n_fail++; $display("FAIL reset_in_freeze: got v=%b a=%h want 0 0", exe_valid, alu_a);
    end
    @(negedge clk); rst = 1'b0; freeze = 1'b0;
    tick();
    n_checks++;
    if (alu_a !== 32'h99 || alu_cmd !== 4'd7) begin
      n_fail++; $display("FAIL post_reset_capture: got a=%h cmd=%0d want 99 7", alu_a, alu_cmd);
    end
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    drive_id(4'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    id_valid = 1'b0;
    clear_fwd();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    test_reset();
    test_capture();
    test_priority();
    test_imm_store();
    test_load_use();
    test_flush_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
